// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the write-back queue.
package wb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue_decoder.sv
// One-hot decode of a queued entry's destination register, gated by entry validity.
module decoder_5to32
   import wb_pkg::*;
(
   input  logic                en,
   input  logic [ADDR_W-1:0]   sel,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back FIFO merging load and ALU results onto the single register-file
// write port, with a per-register pending mask for RAW hazard stalls.
module wb_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ld_valid,
   input  logic [ADDR_W-1:0]         ld_rd,
   input  logic [DATA_W-1:0]         ld_data,
   output logic                      ld_ready,
   input  logic                      alu_valid,
   input  logic [ADDR_W-1:0]         alu_rd,
   input  logic [DATA_W-1:0]         alu_data,
   output logic                      alu_ready,
   input  logic                      wb_stall,
   output logic                      reg_wr,
   output logic [ADDR_W-1:0]         rd,
   output logic [DATA_W-1:0]         busW,
   output logic [NUM_REGS-1:0]       pending,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_entry_t                        mem [DEPTH];
   logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
   logic                             ld_fire, alu_fire, deq;
   logic [PTR_W-1:0]                 alu_idx;
   logic [DEPTH-1:0]                 ent_vld;
   logic [DEPTH-1:0][NUM_REGS-1:0]   dec_out;
   logic [NUM_REGS-1:0]              pend_or;
   wb_entry_t                        head;

   // Readiness looks only at registered occupancy; the load owns the last free slot.
   assign ld_ready  = count < CNT_W'(DEPTH);
   assign alu_ready = (count <= CNT_W'(DEPTH-2)) ||
                      ((count == CNT_W'(DEPTH-1)) && !ld_valid);

   // Register-zero writes complete the handshake but never occupy a slot.
   assign ld_fire  = ld_valid  && ld_ready  && (ld_rd  != REG_ZERO);
   assign alu_fire = alu_valid && alu_ready && (alu_rd != REG_ZERO);
   assign alu_idx  = wr_ptr + PTR_W'(ld_fire);

   assign head   = mem[rd_ptr];
   assign reg_wr = (count != '0) && !wb_stall;
   assign deq    = reg_wr;
   assign rd     = (count != '0) ? head.rd   : '0;
   assign busW   = (count != '0) ? head.data : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(ld_fire) + PTR_W'(alu_fire);
         rd_ptr <= rd_ptr + PTR_W'(deq);
         count  <= count + CNT_W'(ld_fire) + CNT_W'(alu_fire) - CNT_W'(deq);
      end
   end

   // Payload storage needs no reset: validity comes entirely from pointers and count.
   always_ff @(posedge clk) begin
      if (ld_fire)  mem[wr_ptr]  <= '{rd: ld_rd,  data: ld_data};
      if (alu_fire) mem[alu_idx] <= '{rd: alu_rd, data: alu_data};
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [PTR_W-1:0] off;
      assign off        = PTR_W'(i) - rd_ptr;
      assign ent_vld[i] = CNT_W'(off) < count;

      decoder_5to32 u_dec (
         .en     (ent_vld[i]),
         .sel    (mem[i].rd),
         .onehot (dec_out[i])
      );
   end

   always_comb begin
      pend_or = '0;
      for (int i = 0; i < DEPTH; i++) pend_or = pend_or | dec_out[i];
   end

   assign pending = {pend_or[NUM_REGS-1:1], 1'b0};

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: drive after each rising edge, check at the falling edge.
module tb_wb_queue;
   import wb_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              ld_valid, alu_valid, wb_stall;
   logic [ADDR_W-1:0] ld_rd, alu_rd;
   logic [DATA_W-1:0] ld_data, alu_data;
   logic              ld_ready, alu_ready, reg_wr;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] busW;
   logic [31:0]       pending;
   logic [2:0]        count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_queue #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .wb_stall(wb_stall), .reg_wr(reg_wr), .rd(rd), .busW(busW),
      .pending(pending), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_valid = 0; alu_valid = 0; ld_rd = '0; alu_rd = '0; ld_data = '0; alu_data = '0;
   endtask

   task automatic drv_ld(input logic [4:0] r, input logic [31:0] d);
      ld_valid = 1; ld_rd = r; ld_data = d;
   endtask

   task automatic drv_alu(input logic [4:0] r, input logic [31:0] d);
      alu_valid = 1; alu_rd = r; alu_data = d;
   endtask

   initial begin
      reset = 0; wb_stall = 0; idle();
      @(negedge clk);
      chk("rst_reg_wr", reg_wr, 0);
      chk("rst_rd", rd, 0);
      chk("rst_busW", busW, 0);
      chk("rst_pending", pending, 0);
      chk("rst_count", count, 0);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_alu_ready", alu_ready, 1);
      #2 reset = 1;
      tick();

      // single ALU write
      drv_alu(7, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_alu_ready", alu_ready, 1);
      tick(); idle();
      @(negedge clk);
      chk("t1_reg_wr", reg_wr, 1);
      chk("t1_rd", rd, 7);
      chk("t1_busW", busW, 32'hDEADBEEF);
      chk("t1_pending", pending, 32'h80);
      chk("t1_count", count, 1);
      tick();
      @(negedge clk);
      chk("t1_count_after", count, 0);
      chk("t1_pending_after", pending, 0);
      chk("t1_reg_wr_after", reg_wr, 0);
      tick();

      // dual enqueue ordering, same destination
      drv_ld(3, 32'h11); drv_alu(3, 32'h22);
      tick(); idle();
      @(negedge clk);
      chk("t2_count", count, 2);
      chk("t2_busW0", busW, 32'h11);
      chk("t2_pend0", pending, 32'h8);
      tick();
      @(negedge clk);
      chk("t2_reg_wr1", reg_wr, 1);
      chk("t2_busW1", busW, 32'h22);
      chk("t2_pend1", pending, 32'h8);
      tick();
      @(negedge clk);
      chk("t2_pend2", pending, 0);
      chk("t2_count2", count, 0);
      tick();

      // full and load priority for the last slot
      wb_stall = 1;
      drv_ld(1, 32'hA1); drv_alu(2, 32'hA2);
      tick(); idle();
      drv_alu(3, 32'hA3);
      tick(); idle();
      drv_ld(4, 32'hA4); drv_alu(5, 32'hA5);
      @(negedge clk);
      chk("t3_count3", count, 3);
      chk("t3_ld_ready", ld_ready, 1);
      chk("t3_alu_ready", alu_ready, 0);
      chk("t3_stall_reg_wr", reg_wr, 0);
      chk("t3_stall_rd", rd, 1);
      chk("t3_stall_busW", busW, 32'hA1);
      tick(); idle();
      @(negedge clk);
      chk("t3_count4", count, 4);
      chk("t3_full_ld_ready", ld_ready, 0);
      chk("t3_full_alu_ready", alu_ready, 0);
      chk("t3_pending", pending, 32'h1E);
      chk("t3_hold_rd", rd, 1);
      tick();
      wb_stall = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t3_drain_wr", reg_wr, 1);
         chk("t3_drain_rd", rd, k);
         chk("t3_drain_busW", busW, 32'hA0 + k);
         tick();
      end
      @(negedge clk);
      chk("t3_empty", count, 0);
      chk("t3_empty_wr", reg_wr, 0);
      tick();

      // register zero is accepted and dropped
      drv_alu(0, 32'h55);
      @(negedge clk);
      chk("t4_alu_ready", alu_ready, 1);
      tick(); idle();
      @(negedge clk);
      chk("t4_count", count, 0);
      chk("t4_reg_wr", reg_wr, 0);
      chk("t4_pending", pending, 0);
      tick();

      // stream 10 ALU results, pointers wrap
      for (int k = 1; k <= 10; k++) begin
         drv_alu(k[4:0], 32'h100 + k);
         @(negedge clk);
         if (k > 1) begin
            chk("t5_count", count, 1);
            chk("t5_reg_wr", reg_wr, 1);
            chk("t5_rd", rd, k - 1);
            chk("t5_busW", busW, 32'h100 + k - 1);
         end
         tick();
      end
      idle();
      @(negedge clk);
      chk("t5_last_rd", rd, 10);
      chk("t5_last_busW", busW, 32'h10A);
      tick();
      @(negedge clk);
      chk("t5_count_end", count, 0);
      tick();

      // reset mid-operation
      wb_stall = 1;
      drv_ld(9, 32'h9); drv_alu(10, 32'hA);
      tick(); idle();
      drv_alu(11, 32'hB);
      tick(); idle();
      @(negedge clk);
      chk("t6_count3", count, 3);
      #2 reset = 0;
      #1;
      chk("t6_rst_reg_wr", reg_wr, 0);
      chk("t6_rst_rd", rd, 0);
      chk("t6_rst_busW", busW, 0);
      chk("t6_rst_pending", pending, 0);
      chk("t6_rst_count", count, 0);
      tick();
      @(negedge clk);
      #2 reset = 1; wb_stall = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_post_count", count, 0);
         chk("t6_post_ld_ready", ld_ready, 1);
         chk("t6_post_alu_ready", alu_ready, 1);
         chk("t6_post_reg_wr", reg_wr, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
